// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and data stages onto one req/ack memory port
//
// Purpose: shares a single-ported unified memory between the instruction-fetch
// and data-memory stages. The data stage wins ties because it is the older
// instruction. Each access waits for mem_ack, and a wait counter aborts an
// access that is never acknowledged.
//
// Optional feature: define ARB_FETCH_BUF_EN to add a one-entry fetch buffer.
// A repeated fetch of the last fetched address is then served without a
// memory access.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   if_req/if_addr                fetch request (held until if_done)
//   if_rdata/if_done              fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata     data request (held until d_done)
//   d_rdata/d_done                load data, one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata   registered memory request, held until mem_ack
//   mem_rdata/mem_ack             memory read data and acknowledge
//   pipe_stall                    combinational stall while either stage waits
//   timeout_err                   sticky flag: an access timed out
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          pipe_stall,
    output logic          timeout_err
);

    typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;

    // The counter holds the number of completed wait cycles. The access is
    // abandoned at the end of the TIMEOUT-th cycle that sees no ack.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t        state_q;
    logic [7:0]    cnt_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          if_done_q;
    logic          d_done_q;
    logic          timeout_err_q;

    // A requester whose done pulse is showing is still dropping its req.
    // Ignoring it here prevents a second issue of the same access.
    logic d_want;
    logic i_want;
    logic cnt_expired;

    assign d_want      = d_req & ~d_done_q;
    assign i_want      = if_req & ~if_done_q;
    assign cnt_expired = (cnt_q == CNT_LAST);

    logic          buf_hit;
    logic [DW-1:0] buf_rdata;

`ifdef ARB_FETCH_BUF_EN
    logic          buf_valid_q;
    logic [AW-1:0] buf_addr_q;
    logic [DW-1:0] buf_data_q;

    assign buf_hit   = buf_valid_q & (buf_addr_q == if_addr);
    assign buf_rdata = buf_data_q;

    // The buffer is filled only by acknowledged fetches. Any granted store
    // invalidates it, because the store may alias the buffered instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else if (state_q == IDLE && d_want && d_we) begin
            buf_valid_q <= 1'b0;
        end else if (state_q == GNT_I && mem_ack) begin
            buf_valid_q <= 1'b1;
            buf_addr_q  <= mem_addr_q;
            buf_data_q  <= mem_rdata;
        end
    end
`else
    assign buf_hit   = 1'b0;
    assign buf_rdata = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            if_done_q     <= 1'b0;
            d_done_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_want) begin
                        state_q     <= GNT_D;
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                    end else if (i_want) begin
                        if (buf_hit) begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= buf_rdata;
                        end else begin
                            state_q    <= GNT_I;
                            cnt_q      <= '0;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= if_addr;
                        end
                    end
                end
                GNT_D: begin
                    if (mem_ack) begin
                        if (!mem_we_q) begin
                            d_rdata_q <= mem_rdata;
                        end
                        d_done_q  <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (cnt_expired) begin
                        timeout_err_q <= 1'b1;
                        d_rdata_q     <= '0;
                        d_done_q      <= 1'b1;
                        mem_req_q     <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                GNT_I: begin
                    if (mem_ack) begin
                        if_rdata_q <= mem_rdata;
                        if_done_q  <= 1'b1;
                        mem_req_q  <= 1'b0;
                        state_q    <= IDLE;
                    end else if (cnt_expired) begin
                        timeout_err_q <= 1'b1;
                        if_rdata_q    <= '0;
                        if_done_q     <= 1'b1;
                        mem_req_q     <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign if_done     = if_done_q;
    assign d_done      = d_done_q;
    assign timeout_err = timeout_err_q;
    assign pipe_stall  = (if_req & ~if_done_q) | (d_req & ~d_done_q);

endmodule
